// File: rtl/hpam_pkg.sv
// hpam_pkg: shared types and constants for the HPAM multiplier family.
// Holds the controller state encoding, operand width and iteration count, and
// the two full-adder cells (exact and approximate) used by the SRCA(8,4) adder.
package hpam_pkg;

    localparam int unsigned MUL_W    = 8;
    localparam int unsigned MUL_ITER = 8;
    // Segment width of the SRCA adder; the low bit of each segment is approximate.
    localparam int unsigned SRCA_SEG = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    // Exact full adder, returns {cout, sum}.
    function automatic logic [1:0] efa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Approximate full adder, returns {cout, sum}. The incoming carry only
    // forces the sum bit high; it never propagates further.
    function automatic logic [1:0] afa(input logic x, input logic y, input logic ci);
        return {x & y, (x ^ y) | ci};
    endfunction

endpackage

// File: rtl/srca_mul_ctrl_if.sv
// srca_mul_ctrl_if: operand/result handshake bundle for srca_mul_ctrl.
// Signals: in_valid/in_ready/a/b/approx (operand side), out_valid/out_ready/
// product (result side), busy (controller not idle).
// Modports: master drives operands and accepts results; slave is the controller.
interface srca_mul_ctrl_if ();
    import hpam_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [MUL_W-1:0]     a;
    logic [MUL_W-1:0]     b;
    logic                 approx;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*MUL_W-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/add8_sel.sv
// add8_sel: 8-bit adder with selectable exactness, carry-in tied to 0.
// Ports: x, y   - addends
//        mode   - 1 selects SRCA(8,4), 0 selects the exact adder
//        sum    - 9-bit {carry, sum}
// SRCA(8,4): two 4-bit ripple segments; bits 0 and 4 use the approximate cell,
// and the carry out of bit 3 feeds bit 4.
module add8_sel import hpam_pkg::*; (
    input  logic [MUL_W-1:0] x,
    input  logic [MUL_W-1:0] y,
    input  logic             mode,
    output logic [MUL_W:0]   sum
);

    logic [MUL_W:0]   exact_sum;
    logic [MUL_W-1:0] srca_s;
    logic [MUL_W:0]   carry;
    logic [1:0]       cs;

    assign exact_sum = {1'b0, x} + {1'b0, y};

    always_comb begin
        carry  = '0;
        srca_s = '0;
        cs     = '0;
        for (int unsigned i = 0; i < MUL_W; i++) begin
            if ((i % SRCA_SEG) == 0) begin
                cs = afa(x[i], y[i], carry[i]);
            end else begin
                cs = efa(x[i], y[i], carry[i]);
            end
            srca_s[i]    = cs[0];
            carry[i + 1] = cs[1];
        end
    end

    assign sum = mode ? {carry[MUL_W], srca_s} : exact_sum;

endmodule

// File: rtl/srca_mul_ctrl.sv
// srca_mul_ctrl: sequential 8x8 unsigned shift-and-add multiplier sharing one
// 8-bit adder (exact or SRCA(8,4), chosen per operation) over 8 iterations.
// Ports: clk - clock, rising edge
//        rst - synchronous active-high reset
//        bus - handshake bundle (slave side): operands in, product out, busy
// Fixed latency: accept, 8 RUN cycles, DONE held until out_ready, then IDLE.
module srca_mul_ctrl import hpam_pkg::*; (
    input logic           clk,
    input logic           rst,
    srca_mul_ctrl_if.slave bus
);

    mul_state_t       state_q, state_d;
    logic [MUL_W-1:0] mcand_q, mcand_d;
    logic [MUL_W-1:0] acc_hi_q, acc_hi_d;
    logic [MUL_W-1:0] acc_lo_q, acc_lo_d;
    logic             mode_q, mode_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [MUL_W:0]   add_sum;
    logic [MUL_W:0]   step_sum;

    add8_sel u_add (
        .x    (acc_hi_q),
        .y    (mcand_q),
        .mode (mode_q),
        .sum  (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        // Add only when the current multiplier bit is set.
        step_sum = acc_lo_q[0] ? add_sum : {1'b0, acc_hi_q};

        unique case (state_q)
            IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone means accept.
                if (bus.in_valid) begin
                    mcand_d  = bus.a;
                    mode_d   = bus.approx;
                    acc_hi_d = '0;
                    acc_lo_d = bus.b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = {step_sum, acc_lo_q[MUL_W-1:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = (state_q == DONE) ? {acc_hi_q, acc_lo_q} : '0;

endmodule

// File: doc/srca_mul_ctrl.md
# srca_mul_ctrl

Sequential 8x8 unsigned shift-and-add multiplier controller that time-shares one 8-bit adder across eight iterations. The adder is selectable per operation: exact, or the segmented approximate SRCA(8,4) adder. It sits beside the combinational HPAM multiplier as a low-area alternative and is the reference harness for comparing approximate-adder error in an iterative context. Operands enter and results leave over valid/ready handshakes.

## Interface
- No parameters. Width is fixed at 8x8 -> 16 to match the SRCA(8,4) segmentation.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `approx` in 1: 1 selects the SRCA(8,4) adder, 0 selects the exact adder. Sampled with the operands.
- `out_valid` out 1: `product` is valid.
- `out_ready` in 1: consumer accepts the product.
- `product` out 16: result.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: 8 iterations.
  - DONE: `out_valid`=1.
- Accept: an accept happens on `in_valid && in_ready`. On accept, load:
  - `mcand`<=`a`, `mode`<=`approx`
  - `acc_hi`<=0, `acc_lo`<=`b`, `cnt`<=0
  - state -> RUN.
- Each RUN cycle:
  - If `acc_lo[0]`=1: `{c,s}` = adder(`acc_hi`, `mcand`, cin=0). Otherwise `{c,s}` = `{0,acc_hi}`.
  - Then `{acc_hi,acc_lo}` <= `{c, s, acc_lo[7:1]}` (17-bit value truncated to 16 by the shift).
  - `cnt`<=`cnt`+1.
  - When `cnt`==7, state -> DONE.
- Adder in exact mode: 9-bit sum `{c,s}` = `acc_hi`+`mcand`.
- Adder in approx mode: `{c,s}` is the SRCA(8,4) function, cin tied 0. That is two 4-bit ripple blocks; bit 0 and bit 4 use the approximate FA cell; the carry passes from bit 3 into bit 4.
- `mode` is held constant through RUN. A change on `approx` after accept has no effect.
- DONE: `product`={`acc_hi`,`acc_lo`}, held stable. State -> IDLE when `out_ready`=1.
- `product` is 0 whenever state is not DONE. Intermediate accumulator values are never exposed.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there; operands are not captured.
- Exact mode result equals `a*b` for all 65536 operand pairs.
- `b`=0 still takes 8 RUN cycles. There is no early termination, so latency is fixed.
- `cnt` is 3 bits and wraps 7->0 only on the transition to DONE. It is not reused outside RUN.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0, all registers 0.
- `rst` asserted in any state, including mid-RUN or DONE with the product unconsumed: the next edge returns to IDLE and the in-flight result is discarded.
- Latency: accept at edge T, RUN for edges T+1..T+8, `out_valid`=1 in the cycle after edge T+8.
- `out_valid` held until `out_ready`. Backpressure can stall indefinitely with no loss.
- Throughput: 10 cycles per op minimum (accept, 8 RUN, DONE with `out_ready`=1, then IDLE). The IDLE bubble after DONE is required; `in_ready` is not asserted in DONE even if `out_ready`=1.
- All outputs are registered or decoded from the state register only. There is no combinational path from `in_valid`/`out_ready` to any output.
- The adder path is combinational within one RUN cycle: `acc_hi` -> adder -> `acc_hi`.

## Structure
- Shared package `hpam_pkg`:
  - state enum `mul_state_t` {IDLE, RUN, DONE}
  - constants `MUL_W`=8, `MUL_ITER`=8
- Sub-module `add8_sel`: muxes exact 9-bit add against an SRCA(8,4) instance on `mode`. The controller instantiates it exactly once.
- The controller FSM, counter and accumulator stay in `srca_mul_ctrl`.

## Test plan
- Reset then idle: after `rst`, `in_ready`=1, `out_valid`=0, `product`=0; holds with `in_valid`=0.
- Exact mode, `a`=8'hFF, `b`=8'hFF, `approx`=0, `out_ready`=1: `out_valid` rises 9 cycles after accept, `product`=16'hFE01, `in_ready` returns one cycle after DONE.
- Exact mode sweep of all 65536 pairs: `product`==`a*b`. Approx mode sweep: `product` matches a bit-level model iterating the SRCA(8,4) function. For example, `a`=8'h01, `b`=8'h01 gives 16'h0001 in both modes.
- Backpressure: `out_ready`=0 for 20 cycles in DONE. `product` stays stable, `in_valid` pulses are ignored, and release transfers exactly one result.
- Reset mid-RUN at iteration 4 with `a`=8'h12, `b`=8'h34: back to IDLE next cycle, no `out_valid`. A following op `a`=8'h03, `b`=8'h05 gives 16'h000F.
- Mode latch: accept with `approx`=0, then toggle `approx` during RUN. The result equals the exact product.
